// File: rtl/sc_lives_pkg.sv
// Shared definitions for the lives manager: FSM state encodings and default parameters.
package sc_lives_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE = 2'b00,
    ST_GUARD = 2'b01,
    ST_OVER  = 2'b10
  } state_t;

  localparam int DEF_DATAWIDTH       = 3;
  localparam int DEF_INIT_LIVES      = 3;
  localparam int DEF_MAX_LIVES       = 7;
  localparam int DEF_HITGUARD_CYCLES = 25000000;

endpackage

// File: rtl/sc_falledge_det.sv
// Active-low falling-edge detector: pulses on the first low sample after a high sample.
module sc_falledge_det (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in_low,
  output logic pulse
);

  logic prev_high_p0;
  logic armed_p0;

  // History stage: after async reset the input must be seen high once before it can fire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_high_p0 <= 1'b1;
      armed_p0     <= 1'b0;
    end else if (clr) begin
      prev_high_p0 <= 1'b1;
      armed_p0     <= 1'b1;
    end else begin
      prev_high_p0 <= in_low;
      if (in_low)
        armed_p0 <= 1'b1;
    end
  end

  assign pulse = armed_p0 & prev_high_p0 & ~in_low;

endmodule

// File: rtl/sc_lives_manager.sv
// Lives/guard/game-over manager. Optional extra-life input enabled by SC_LIVES_MANAGER_BONUS_EN.
module sc_lives_manager
  import sc_lives_pkg::*;
#(
  parameter int DATAWIDTH       = DEF_DATAWIDTH,
  parameter int INIT_LIVES      = DEF_INIT_LIVES,
  parameter int MAX_LIVES       = DEF_MAX_LIVES,
  parameter int HITGUARD_CYCLES = DEF_HITGUARD_CYCLES
) (
  input  logic                 SC_LIVES_MANAGER_CLOCK_50,
  input  logic                 SC_LIVES_MANAGER_RESET_InHigh,
  input  logic                 SC_LIVES_MANAGER_HIT_InLow,
`ifdef SC_LIVES_MANAGER_BONUS_EN
  input  logic                 SC_LIVES_MANAGER_BONUS_InLow,
`endif
  input  logic                 SC_LIVES_MANAGER_RESTART_InHigh,
  output logic [DATAWIDTH-1:0] SC_LIVES_MANAGER_LIVES_OutBUS,
  output logic                 SC_LIVES_MANAGER_GAMEOVER_Out,
  output logic                 SC_LIVES_MANAGER_GUARD_Out
);

  localparam int TMR_W = $clog2(HITGUARD_CYCLES + 1);
  localparam logic [TMR_W-1:0]     TMR_LOAD  = TMR_W'(HITGUARD_CYCLES);
  localparam logic [TMR_W-1:0]     TMR_ONE   = TMR_W'(1);
  localparam logic [DATAWIDTH-1:0] LIVES_INI = DATAWIDTH'(INIT_LIVES);
  localparam logic [DATAWIDTH-1:0] LIVES_MAX = DATAWIDTH'(MAX_LIVES);
  localparam logic [DATAWIDTH-1:0] LIVES_ONE = DATAWIDTH'(1);

  generate
    if (!(INIT_LIVES >= 1 && INIT_LIVES <= MAX_LIVES &&
          MAX_LIVES <= (2 ** DATAWIDTH) - 1 && HITGUARD_CYCLES >= 1)) begin : g_param_err
      $error("sc_lives_manager: illegal parameters (need 1<=INIT_LIVES<=MAX_LIVES<=2^DATAWIDTH-1, HITGUARD_CYCLES>=1)");
    end
  endgenerate

  function automatic logic [DATAWIDTH-1:0] sat_inc(input logic [DATAWIDTH-1:0] v);
    if (v >= LIVES_MAX)
      return LIVES_MAX;
    return v + LIVES_ONE;
  endfunction

  logic clk;
  logic rst;
  logic restart;
  logic hit_evt;
  logic bonus_evt;

  assign clk     = SC_LIVES_MANAGER_CLOCK_50;
  assign rst     = SC_LIVES_MANAGER_RESET_InHigh;
  assign restart = SC_LIVES_MANAGER_RESTART_InHigh;

  sc_falledge_det u_hit_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (restart),
    .in_low (SC_LIVES_MANAGER_HIT_InLow),
    .pulse  (hit_evt)
  );

`ifdef SC_LIVES_MANAGER_BONUS_EN
  sc_falledge_det u_bonus_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (restart),
    .in_low (SC_LIVES_MANAGER_BONUS_InLow),
    .pulse  (bonus_evt)
  );
`else
  assign bonus_evt = 1'b0;
`endif

  state_t                 state_p0, state_n;
  logic [DATAWIDTH-1:0]   lives_p0, lives_n;
  logic [TMR_W-1:0]       timer_p0, timer_n;
  logic                   guard_p0, guard_n;
  logic                   over_p0,  over_n;

  // State register stage: every output comes straight from here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= ST_ALIVE;
      lives_p0 <= LIVES_INI;
      timer_p0 <= '0;
      guard_p0 <= 1'b0;
      over_p0  <= 1'b0;
    end else begin
      state_p0 <= state_n;
      lives_p0 <= lives_n;
      timer_p0 <= timer_n;
      guard_p0 <= guard_n;
      over_p0  <= over_n;
    end
  end

  always_comb begin
    state_n = state_p0;
    lives_n = lives_p0;
    timer_n = timer_p0;
    guard_n = guard_p0;
    over_n  = over_p0;
    if (restart) begin
      state_n = ST_ALIVE;
      lives_n = LIVES_INI;
      timer_n = '0;
      guard_n = 1'b0;
      over_n  = 1'b0;
    end else begin
      case (state_p0)
        ST_ALIVE: begin
          if (hit_evt && bonus_evt) begin
            // Hit and extra life cancel out, but the hit still earns a guard window
            state_n = ST_GUARD;
            timer_n = TMR_LOAD;
            guard_n = 1'b1;
          end else if (hit_evt) begin
            if (lives_p0 > LIVES_ONE) begin
              lives_n = lives_p0 - LIVES_ONE;
              state_n = ST_GUARD;
              timer_n = TMR_LOAD;
              guard_n = 1'b1;
            end else begin
              lives_n = '0;
              state_n = ST_OVER;
              over_n  = 1'b1;
            end
          end else if (bonus_evt) begin
            lives_n = sat_inc(lives_p0);
          end
        end
        ST_GUARD: begin
          if (bonus_evt)
            lives_n = sat_inc(lives_p0);
          timer_n = timer_p0 - TMR_ONE;
          if (timer_p0 <= TMR_ONE) begin
            state_n = ST_ALIVE;
            timer_n = '0;
            guard_n = 1'b0;
          end
        end
        ST_OVER: begin
          lives_n = '0;
        end
        default: begin
          state_n = ST_ALIVE;
          lives_n = LIVES_INI;
          timer_n = '0;
          guard_n = 1'b0;
          over_n  = 1'b0;
        end
      endcase
    end
  end

  assign SC_LIVES_MANAGER_LIVES_OutBUS = lives_p0;
  assign SC_LIVES_MANAGER_GAMEOVER_Out = over_p0;
  assign SC_LIVES_MANAGER_GUARD_Out    = guard_p0;

endmodule

// File: tb/tb_sc_lives_manager.sv
// Directed plus randomized bench for sc_lives_manager against an abstract lives/guard model.
module tb_sc_lives_manager;

  localparam int DW    = 3;
  localparam int INIT  = 3;
  localparam int MAXL  = 7;
  localparam int GUARD = 4;
`ifdef SC_LIVES_MANAGER_BONUS_EN
  localparam bit BONUS_ON = 1'b1;
`else
  localparam bit BONUS_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          hit;
  logic          bonus;
  logic          restart;
  logic [DW-1:0] lives_o;
  logic          over_o;
  logic          guard_o;

  int checks;
  int failures;

  // Abstract model: lives count, game-over flag, remaining guard clocks, "last seen high" flags
  int m_lives;
  bit m_over;
  int m_gl;
  bit m_ph;
  bit m_pb;

  sc_lives_manager #(
    .DATAWIDTH       (DW),
    .INIT_LIVES      (INIT),
    .MAX_LIVES       (MAXL),
    .HITGUARD_CYCLES (GUARD)
  ) dut (
    .SC_LIVES_MANAGER_CLOCK_50       (clk),
    .SC_LIVES_MANAGER_RESET_InHigh   (rst),
    .SC_LIVES_MANAGER_HIT_InLow      (hit),
`ifdef SC_LIVES_MANAGER_BONUS_EN
    .SC_LIVES_MANAGER_BONUS_InLow    (bonus),
`endif
    .SC_LIVES_MANAGER_RESTART_InHigh (restart),
    .SC_LIVES_MANAGER_LIVES_OutBUS   (lives_o),
    .SC_LIVES_MANAGER_GAMEOVER_Out   (over_o),
    .SC_LIVES_MANAGER_GUARD_Out      (guard_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task model_reset();
    m_lives = INIT;
    m_over  = 1'b0;
    m_gl    = 0;
    m_ph    = 1'b0;
    m_pb    = 1'b0;
  endtask

  task model_step(input logic h, input logic b, input logic r);
    bit hev, bev;
    hev  = m_ph && !h;
    bev  = BONUS_ON && m_pb && !b;
    m_ph = h;
    m_pb = b;
    if (r) begin
      m_lives = INIT;
      m_over  = 1'b0;
      m_gl    = 0;
      m_ph    = 1'b1;
      m_pb    = 1'b1;
    end else if (m_over) begin
      m_lives = 0;
    end else if (m_gl > 0) begin
      m_gl = m_gl - 1;
      if (bev) m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
    end else if (hev && bev) begin
      m_gl = GUARD;
    end else if (hev) begin
      if (m_lives > 1) begin
        m_lives = m_lives - 1;
        m_gl    = GUARD;
      end else begin
        m_lives = 0;
        m_over  = 1'b1;
      end
    end else if (bev) begin
      m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
    end
  endtask

  task check_model(input string tag);
    chk({tag, "_lives"}, 32'(lives_o), 32'(m_lives));
    chk({tag, "_over"},  32'(over_o),  32'(m_over));
    chk({tag, "_guard"}, 32'(guard_o), 32'(m_gl > 0));
  endtask

  task step(input logic h, input logic b, input logic r);
    hit     = h;
    bonus   = b;
    restart = r;
    model_step(h, b, r);
    @(posedge clk);
    #1;
    check_model("step");
  endtask

  task async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_model("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int gc;

  initial begin
    checks   = 0;
    failures = 0;
    hit      = 1'b1;
    bonus    = 1'b1;
    restart  = 1'b0;
    rst      = 1'b0;

    // Reset seen before the first clock edge
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_lives", 32'(lives_o), 32'(3));
    chk("rst_over",  32'(over_o),  32'(0));
    chk("rst_guard", 32'(guard_o), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 1, 0);
    step(1, 1, 0);

    // Held-low hit: one decrement, exactly GUARD clocks of guard
    step(0, 1, 0);
    chk("hold_first_lives", 32'(lives_o), 32'(2));
    chk("hold_first_guard", 32'(guard_o), 32'(1));
    gc = 1;
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 0);
      gc += int'(guard_o);
    end
    chk("hold_guard_len", 32'(gc), 32'(GUARD));
    chk("hold_lives", 32'(lives_o), 32'(2));
    step(1, 1, 0);

    // Second edge inside guard is ignored; a hit after guard decrements again
    step(1, 1, 1);
    chk("restart1_lives", 32'(lives_o), 32'(3));
    step(1, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    chk("guard_ignore_lives", 32'(lives_o), 32'(2));
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    chk("guard_end", 32'(guard_o), 32'(0));
    step(0, 1, 0);
    chk("hit2_lives", 32'(lives_o), 32'(1));
    gc = int'(guard_o);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0);
      gc += int'(guard_o);
    end
    chk("hit2_guard_len", 32'(gc), 32'(GUARD));

    // Last life, then game over ignores events until restart
    step(0, 1, 0);
    chk("over_lives", 32'(lives_o), 32'(0));
    chk("over_flag",  32'(over_o),  32'(1));
    chk("over_guard", 32'(guard_o), 32'(0));
    step(1, 1, 0);
    step(0, 0, 0);
    chk("over_hold_lives", 32'(lives_o), 32'(0));
    chk("over_hold_flag",  32'(over_o),  32'(1));
    step(1, 1, 1);
    chk("restart2_lives", 32'(lives_o), 32'(3));
    chk("restart2_over",  32'(over_o),  32'(0));

    // Bonus saturation and simultaneous hit+bonus
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0);
      step(1, 1, 0);
    end
`ifdef SC_LIVES_MANAGER_BONUS_EN
    chk("bonus_sat", 32'(lives_o), 32'(7));
`else
    chk("no_bonus_lives", 32'(lives_o), 32'(3));
`endif
    step(0, 0, 0);
`ifdef SC_LIVES_MANAGER_BONUS_EN
    chk("hitbonus_lives", 32'(lives_o), 32'(7));
`endif
    chk("hitbonus_guard", 32'(guard_o), 32'(1));
    gc = 1;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0);
      gc += int'(guard_o);
    end
    chk("hitbonus_guard_len", 32'(gc), 32'(GUARD));

    // Async reset in the middle of a guard window
    step(1, 1, 1);
    step(1, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("pre_arst_lives", 32'(lives_o), 32'(2));
    chk("pre_arst_guard", 32'(guard_o), 32'(1));
    async_reset();
    chk("arst_lives", 32'(lives_o), 32'(3));
    chk("arst_guard", 32'(guard_o), 32'(0));
    for (int i = 0; i < 3; i++) step(1, 1, 0);

    // Restart wins over a simultaneous hit
    step(0, 1, 1);
    chk("restart_hit_lives", 32'(lives_o), 32'(3));
    chk("restart_hit_guard", 32'(guard_o), 32'(0));
    step(1, 1, 0);
    chk("restart_hit_after", 32'(guard_o), 32'(0));

    // Hit held low through reset release does not count until it rises and falls
    hit = 1'b0;
    async_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("held_through_rst", 32'(lives_o), 32'(3));
    step(1, 1, 0);
    step(0, 1, 0);
    chk("held_then_edge", 32'(lives_o), 32'(2));

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 150) == 0) begin
        async_reset();
      end else begin
        step(logic'($urandom_range(0, 2) != 0),
             logic'($urandom_range(0, 3) != 0),
             logic'($urandom_range(0, 60) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
